alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle control sequencer that drives the ezRISC ALU datapath from the control side. It accepts one ALU operation per valid/ready handshake and generates the 4-bit ALU control code plus the register-transfer strobes for the whole operation. Those strobes are: source A to bus → Y, source B to bus → ALU → Z, then Zlo/Zhi write-back. It sits between instruction decode and the shared-bus datapath, and is the producer of the ALU's control input and the consumer of its 64-bit Z result.

## Interface
- REG_SIZE, 32: datapath width; Z is 2*REG_SIZE.
- MUL_LAT, 4: EXEC cycles held for mul (≥1).
- DIV_LAT, 8: EXEC cycles held for div (≥1).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  request present.
- op_code  in  4  ALU operation (and 0000, or 0001, add 0010, sub 0011, shr 0100, shl 0101, ror 0110, rol 0111, mul 1000, div 1001, neg 1010, not 1011).
- op_ready  out  1  sequencer idle, can accept.
- alu_ctrl  out  4  ALU control code, registered.
- ra_out  out  1  drive source register A onto bus.
- rb_out  out  1  drive source register B onto bus.
- y_in  out  1  latch bus into Y.
- z_in  out  1  latch ALU result into Z.
- zlo_out  out  1  drive Z[REG_SIZE-1:0] onto bus.
- zhi_out  out  1  drive Z[2*REG_SIZE-1:REG_SIZE] onto bus.
- rd_in  out  1  latch bus into destination register.
- lo_in  out  1  latch bus into LO.
- hi_in  out  1  latch bus into HI.
- done  out  1  one-cycle pulse, operation complete.
- err  out  1  one-cycle pulse, illegal op_code (1100–1111) accepted.

## Operation
- States: IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, ERR.
- IDLE:
  - op_ready=1.
  - Handshake op_valid&op_ready latches op_code into alu_ctrl.
  - Legal code → LOAD_Y; illegal code → ERR, and alu_ctrl is left unchanged.
- LOAD_Y: ra_out=1, y_in=1 → EXEC.
- EXEC:
  - rb_out=1 for binary ops. rb_out=0 for neg/not, which are unary and use Y only.
  - Held 1 cycle for ops 0000–0111, 1010, 1011; MUL_LAT cycles for mul; DIV_LAT cycles for div.
  - z_in=1 only in the last EXEC cycle.
  - → WB_LO.
- WB_LO: zlo_out=1.
  - mul/div: lo_in=1 → WB_HI.
  - Other ops: rd_in=1, done=1 → IDLE.
- WB_HI: zhi_out=1, hi_in=1, done=1 → IDLE.
- ERR: err=1, no datapath strobe → IDLE.
- Exactly one bus driver (ra_out, rb_out, zlo_out, zhi_out) is active per cycle, or none.
- EXEC wait counter:
  - Width $clog2(max(MUL_LAT,DIV_LAT))+1.
  - Loaded on entry to EXEC, decremented each EXEC cycle, last cycle at count 1.
- op_valid and op_code are ignored outside IDLE; there is no queueing.

## Timing
- Reset values: state=IDLE, alu_ctrl=0000, counter=0. All strobes, done and err are 0; op_ready=1.
- Reset asserted mid-operation: all strobes drop immediately, without waiting for a clock edge. Any partial write-back is abandoned.
- Strobes are Moore decodes of state. alu_ctrl is stable from the cycle after acceptance until the next acceptance.
- Latency from the handshake edge to the done cycle:
  - single-cycle ops: 3 cycles;
  - mul: 3+MUL_LAT cycles;
  - div: 3+DIV_LAT cycles;
  - illegal op: err in the next cycle, then op_ready=1 in the cycle after.
- op_ready returns in the cycle after done. Back-to-back throughput for add is therefore one op per 4 cycles.

## Structure
- Shared package alu_pkg holds:
  - ALU op-code localparams (ALU_AND … ALU_NOT), reused by the ALU and by decode;
  - sequencer state encoding;
  - an is_legal/is_wide (mul/div) helper function.
- One natural sub-module: alu_seq_wait_cnt (loadable down-counter with last-cycle flag).

## Test plan
- Add: op_code=0010 pulsed in IDLE.
  - Next cycles: {ra_out,y_in}, {rb_out,z_in}, {zlo_out,rd_in,done}.
  - alu_ctrl=0010; op_ready=1 in the following cycle.
- Mul, MUL_LAT=4: EXEC lasts 4 cycles with rb_out=1 and z_in only on the 4th. Then {zlo_out,lo_in}, then {zhi_out,hi_in,done}. Total 7 cycles.
- Not (1011): EXEC has rb_out=0 and z_in=1; write-back goes to rd only.
- Illegal op_code=1101: err=1 for one cycle, no strobes, alu_ctrl keeps its previous value.
- rst raised during the 5th EXEC cycle of div (DIV_LAT=8):
  - all strobes are 0 immediately, with no hi_in/lo_in;
  - after release, op_ready=1 and alu_ctrl=0000.
- op_valid held high with a changing op_code during a sub: it is ignored until done. A new add is accepted in the first IDLE cycle. Checker confirms at most one bus driver is active every cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, sequencer state encoding, op-class helpers.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;
   localparam logic [3:0] ALU_SHR = 4'b0100;
   localparam logic [3:0] ALU_SHL = 4'b0101;
   localparam logic [3:0] ALU_ROR = 4'b0110;
   localparam logic [3:0] ALU_ROL = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1000;
   localparam logic [3:0] ALU_DIV = 4'b1001;
   localparam logic [3:0] ALU_NEG = 4'b1010;
   localparam logic [3:0] ALU_NOT = 4'b1011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_Y = 3'd1,
      S_EXEC   = 3'd2,
      S_WB_LO  = 3'd3,
      S_WB_HI  = 3'd4,
      S_ERR    = 3'd5
   } seq_state_t;

   // Codes above NOT are unassigned.
   function automatic logic is_legal(input logic [3:0] code);
      return code <= ALU_NOT;
   endfunction

   // mul/div produce a 64-bit result written back through LO and HI.
   function automatic logic is_wide(input logic [3:0] code);
      return (code == ALU_MUL) || (code == ALU_DIV);
   endfunction

   // neg/not operate on Y only, so B is never driven.
   function automatic logic is_unary(input logic [3:0] code);
      return (code == ALU_NEG) || (code == ALU_NOT);
   endfunction

endpackage

// File: rtl/alu_seq_wait_cnt.sv
// Loadable down-counter timing the EXEC phase; last flags the final cycle.
module alu_seq_wait_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         last
);

   // Load takes priority; decrement saturates at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && (count != '0))
         count <= count - 1'b1;
   end

   assign last = (count == W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for the shared-bus ALU: Y load, execute, Zlo/Zhi write-back.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int REG_SIZE = 32,
   parameter int MUL_LAT  = 4,
   parameter int DIV_LAT  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_valid,
   input  logic [3:0] op_code,
   output logic       op_ready,
   output logic [3:0] alu_ctrl,
   output logic       ra_out,
   output logic       rb_out,
   output logic       y_in,
   output logic       z_in,
   output logic       zlo_out,
   output logic       zhi_out,
   output logic       rd_in,
   output logic       lo_in,
   output logic       hi_in,
   output logic       done,
   output logic       err
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;

   // The sequencer is width-independent; REG_SIZE only travels with the datapath.
   // An empty guard block keeps an illegal override visible in the hierarchy.
   if (REG_SIZE < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_params
   end

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_last;
   logic             wide;

   assign wide = is_wide(alu_ctrl);

   // EXEC length is chosen from the already-latched op during LOAD_Y.
   assign cnt_load_val = (alu_ctrl == ALU_MUL) ? CNT_W'(MUL_LAT) :
                         (alu_ctrl == ALU_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(1);

   alu_seq_wait_cnt #(.W(CNT_W)) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (state == S_LOAD_Y),
      .load_val (cnt_load_val),
      .dec      (state == S_EXEC),
      .count    (cnt),
      .last     (cnt_last)
   );

   // State machine and op latch; illegal codes leave alu_ctrl untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         alu_ctrl <= ALU_AND;
      end else begin
         case (state)
            S_IDLE:
               if (op_valid) begin
                  if (is_legal(op_code)) begin
                     alu_ctrl <= op_code;
                     state    <= S_LOAD_Y;
                  end else begin
                     state    <= S_ERR;
                  end
               end
            S_LOAD_Y: state <= S_EXEC;
            S_EXEC:   if (cnt_last) state <= S_WB_LO;
            S_WB_LO:  state <= wide ? S_WB_HI : S_IDLE;
            S_WB_HI:  state <= S_IDLE;
            S_ERR:    state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Moore decodes: state is async-reset, so every strobe drops with rst.
   assign op_ready = (state == S_IDLE);
   assign ra_out   = (state == S_LOAD_Y);
   assign y_in     = (state == S_LOAD_Y);
   assign rb_out   = (state == S_EXEC) && !is_unary(alu_ctrl);
   assign z_in     = (state == S_EXEC) && cnt_last;
   assign zlo_out  = (state == S_WB_LO);
   assign lo_in    = (state == S_WB_LO) && wide;
   assign rd_in    = (state == S_WB_LO) && !wide;
   assign zhi_out  = (state == S_WB_HI);
   assign hi_in    = (state == S_WB_HI);
   assign done     = ((state == S_WB_LO) && !wide) || (state == S_WB_HI);
   assign err      = (state == S_ERR);

endmodule
